// File: rtl/convolution_3x3.sv
// Streaming 3x3 signed convolution: kernel and image window are loaded one column per beat,
// and a registered full-precision dot product of the two is produced every clock.
module convolution_3x3 #(
  parameter int unsigned BIT_LEN  = 8,
  parameter int unsigned M_LEN    = 3,
  parameter int unsigned CONV_LEN = 20
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_selecK_I,
  input  logic signed [BIT_LEN-1:0]  i_data0,
  input  logic signed [BIT_LEN-1:0]  i_data1,
  input  logic signed [BIT_LEN-1:0]  i_data2,
  output logic signed [CONV_LEN-1:0] o_data
);

  logic signed [BIT_LEN-1:0]   din   [M_LEN];
  logic signed [BIT_LEN-1:0]   k_q   [M_LEN][M_LEN];
  logic signed [BIT_LEN-1:0]   w_q   [M_LEN][M_LEN];
  logic signed [2*BIT_LEN-1:0] prod  [M_LEN][M_LEN];
  logic signed [CONV_LEN-1:0]  acc_d;

  assign din[0] = i_data0;
  assign din[1] = i_data1;
  assign din[2] = i_data2;

  // Column 2 receives the newest data; older columns shift toward column 0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < M_LEN; r++) begin
        for (int c = 0; c < M_LEN; c++) begin
          k_q[r][c] <= '0;
          w_q[r][c] <= '0;
        end
      end
    end else if (i_valid) begin
      for (int r = 0; r < M_LEN; r++) begin
        if (i_selecK_I) begin
          for (int c = 0; c < M_LEN - 1; c++) w_q[r][c] <= w_q[r][c+1];
          w_q[r][M_LEN-1] <= din[r];
        end else begin
          for (int c = 0; c < M_LEN - 1; c++) k_q[r][c] <= k_q[r][c+1];
          k_q[r][M_LEN-1] <= din[r];
        end
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int r = 0; r < M_LEN; r++) begin
      for (int c = 0; c < M_LEN; c++) begin
        prod[r][c] = k_q[r][c] * w_q[r][c];
        acc_d = acc_d + {{(CONV_LEN - 2*BIT_LEN){prod[r][c][2*BIT_LEN-1]}}, prod[r][c]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data <= '0;
    end else begin
      o_data <= acc_d;
    end
  end

endmodule

// File: tb/tb_convolution_3x3.sv
// Directed and randomized checks of convolution_3x3 against a column-queue reference model.
module tb_convolution_3x3;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_selecK_I = 1'b0;
  logic signed [7:0]  i_data0 = '0;
  logic signed [7:0]  i_data1 = '0;
  logic signed [7:0]  i_data2 = '0;
  logic signed [19:0] o_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: index 0 = oldest column, 2 = newest.
  int kern [3][3];
  int win  [3][3];

  convolution_3x3 dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_selecK_I (i_selecK_I),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .o_data     (o_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic int model_sum();
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += kern[r][c] * win[r][c];
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        kern[r][c] = 0;
        win[r][c]  = 0;
      end
  endtask

  task automatic check(input string tag, input int expected);
    logic signed [19:0] exp20;
    exp20 = 20'(expected);
    vectors++;
    assert (o_data === exp20) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, o_data, exp20);
    end
  endtask

  // One clock: output after the edge must equal the model sum from before the edge.
  task automatic cycle(input string tag, input bit v, input bit s,
                       input int a, input int b, input int c);
    int exp_now;
    int col [3];
    exp_now = model_sum();
    i_valid = v; i_selecK_I = s;
    i_data0 = 8'(a); i_data1 = 8'(b); i_data2 = 8'(c);
    @(posedge i_clk); #1;
    check(tag, exp_now);
    if (v) begin
      col[0] = a; col[1] = b; col[2] = c;
      for (int r = 0; r < 3; r++) begin
        if (s) begin
          win[r][0] = win[r][1]; win[r][1] = win[r][2]; win[r][2] = col[r];
        end else begin
          kern[r][0] = kern[r][1]; kern[r][1] = kern[r][2]; kern[r][2] = col[r];
        end
      end
    end
    i_valid = 1'b0;
  endtask

  // Single valid beat followed by an idle cycle so the result is visible.
  task automatic beat(input string tag, input bit s, input int a, input int b, input int c);
    cycle(tag, 1'b1, s, a, b, c);
    cycle(tag, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2 i_reset = 1'b1;
    #1 check(tag, 0);
    model_clear();
    @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  initial begin
    model_clear();
    @(posedge i_clk); #1;
    mid_reset("reset_initial");
    cycle("reset_idle0", 1'b0, 1'b0, 0, 0, 0);
    cycle("reset_idle1", 1'b0, 1'b0, 0, 0, 0);
    check("reset_hold", 0);

    beat("kload1", 1'b0, 1, 1, 1);
    beat("kload2", 1'b0, 2, 2, 2);
    beat("kload3", 1'b0, 3, 3, 3);
    check("kernel_only", 0);

    beat("img1", 1'b1, 1, 1, 1); check("partial1", 9);
    beat("img2", 1'b1, 2, 2, 2); check("partial2", 24);
    beat("img3", 1'b1, 3, 3, 3); check("full3", 42);
    beat("img4", 1'b1, 4, 4, 4); check("slide4", 60);
    beat("img5", 1'b1, 5, 5, 5); check("slide5", 78);
    beat("img6", 1'b1, 6, 6, 6); check("slide6", 96);
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, 0, 0, 0);
    check("slide_hold", 96);

    for (int i = 0; i < 3; i++) beat("kneg", 1'b0, -128, -128, -128);
    for (int i = 0; i < 3; i++) beat("ineg", 1'b1, -128, -128, -128);
    check("max_pos", 147456);
    for (int i = 0; i < 3; i++) beat("kpos", 1'b0, 127, 127, 127);
    check("max_neg", -146304);

    beat("kid0", 1'b0, 0, 0, 0);
    beat("kid1", 1'b0, 0, 1, 0);
    beat("kid2", 1'b0, 0, 0, 0);
    beat("row1", 1'b1, 1, 2, 3);
    beat("row2", 1'b1, 4, 5, 6);
    beat("row3", 1'b1, 7, 8, 9);
    check("center", 5);
    cycle("burst0", 1'b1, 1'b1, 10, 20, 30);
    cycle("burst1", 1'b1, 1'b1, 10, 20, 30);
    cycle("burst_out", 1'b0, 1'b0, 0, 0, 0);
    check("burst_shift2", 20);
    mid_reset("reset_mid");
    cycle("post_reset", 1'b0, 1'b0, 0, 0, 0);

    // Random interleaved kernel/image traffic with random gaps.
    for (int i = 0; i < 400; i++) begin
      cycle("random", ($urandom_range(0, 3) != 0), 1'($urandom),
            int'($signed(8'($urandom))), int'($signed(8'($urandom))),
            int'($signed(8'($urandom))));
    end
    mid_reset("reset_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
